// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default widths and reset bit period.
// Used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_DATA_WIDTH_DEF   = 8;
    localparam int CONFIG_DATA_WIDTH_DEF = 32;

    // Clocks-per-bit minus 1 loaded at reset.
    localparam int RESET_CPB_M1 = 437;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_CLEANUP = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high serial input.
// Both flops reset to 1 so a reset never looks like a start bit.
module uart_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing with a run-time bit period (CPB-1) latched per frame.
// Optional even parity bit when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_DATA_WIDTH   = UART_DATA_WIDTH_DEF,
    parameter int CONFIG_DATA_WIDTH = CONFIG_DATA_WIDTH_DEF
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic [CONFIG_DATA_WIDTH-1:0] uart_config_data,
    input  logic                         i_Rx_Serial,
    output logic                         o_Rx_DV,
    output logic [UART_DATA_WIDTH-1:0]   o_Rx_Byte,
    output logic                         o_Rx_Frame_Err,
    output logic                         o_Rx_Parity_Err,
    output logic                         o_Rx_Active
);

    localparam int IDX_W = (UART_DATA_WIDTH > 1) ? $clog2(UART_DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_WIDTH - 1);
    localparam logic [CONFIG_DATA_WIDTH-1:0] CFG_RESET = CONFIG_DATA_WIDTH'(RESET_CPB_M1);
    localparam logic [CONFIG_DATA_WIDTH-1:0] CNT_ONE = CONFIG_DATA_WIDTH'(1);

    logic rx_sync;
    logic rx_prev_q;

    uart_sync2 u_sync (
        .clk_i (i_Clock),
        .rst_i (i_Reset),
        .d_i   (i_Rx_Serial),
        .q_o   (rx_sync)
    );

    uart_state_e                  state_q;
    logic [CONFIG_DATA_WIDTH-1:0] count_q;
    logic [CONFIG_DATA_WIDTH-1:0] config_data_q;
    logic [IDX_W-1:0]             bit_idx_q;
    logic [UART_DATA_WIDTH-1:0]   shift_q;
    logic [UART_DATA_WIDTH-1:0]   byte_q;
    logic                         dv_q;
    logic                         frame_err_q;
    logic                         active_q;
`ifdef UART_RX_PARITY_EN
    logic                         parity_bit_q;
    logic                         parity_err_q;
`endif

    logic start_edge;
    logic half_done;
    logic bit_done;

    assign start_edge = rx_prev_q & ~rx_sync;
    assign half_done  = (count_q == (config_data_q >> 1));
    assign bit_done   = (count_q == config_data_q);

    // Sampling uses the delayed copy: the edge is seen one cycle late, so rx_prev_q
    // lines up with the true mid-bit point, which keeps CPB 1 working.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            rx_prev_q     <= 1'b1;
            count_q       <= '0;
            config_data_q <= CFG_RESET;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_q        <= '0;
            dv_q          <= 1'b0;
            frame_err_q   <= 1'b0;
            active_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q  <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            rx_prev_q   <= rx_sync;
            dv_q        <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    count_q   <= '0;
                    bit_idx_q <= '0;
                    if (start_edge) begin
                        config_data_q <= uart_config_data;
                        active_q      <= 1'b1;
                        state_q       <= ST_START;
                    end
                end
                ST_START: begin
                    if (half_done) begin
                        count_q <= '0;
                        if (!rx_prev_q) begin
                            state_q <= ST_DATA;
                        end else begin
                            active_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        count_q            <= '0;
                        shift_q[bit_idx_q] <= rx_prev_q;
                        if (bit_idx_q == LAST_IDX) begin
                            bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= ST_PARITY;
`else
                            state_q   <= ST_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        count_q      <= '0;
                        parity_bit_q <= rx_prev_q;
                        state_q      <= ST_STOP;
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        count_q      <= '0;
                        byte_q       <= shift_q;
                        frame_err_q  <= ~rx_prev_q;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= (^shift_q) ^ parity_bit_q;
`endif
                        dv_q         <= 1'b1;
                        state_q      <= ST_CLEANUP;
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                ST_CLEANUP: begin
                    active_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    active_q <= 1'b0;
                    count_q  <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Frame_Err = frame_err_q;
    assign o_Rx_Active    = active_q;
`ifdef UART_RX_PARITY_EN
    assign o_Rx_Parity_Err = parity_err_q;
`else
    assign o_Rx_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx; drives serial frames and checks received data and flags.
// Exercises the parity path as well when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int W  = 8;
    localparam int CW = 32;

    logic          i_Clock = 1'b0;
    logic          i_Reset = 1'b1;
    logic [CW-1:0] uart_config_data = 32'd437;
    logic          i_Rx_Serial = 1'b1;
    logic          o_Rx_DV;
    logic [W-1:0]  o_Rx_Byte;
    logic          o_Rx_Frame_Err;
    logic          o_Rx_Parity_Err;
    logic          o_Rx_Active;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int           dv_count  = 0;
    int           err_leak  = 0;
    int           bad_flags = 0;
    logic [W-1:0] last_byte = '0;
    logic         last_ferr = 1'b0;
    logic         last_perr = 1'b0;
    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];

    uart_rx #(
        .UART_DATA_WIDTH   (W),
        .CONFIG_DATA_WIDTH (CW)
    ) dut (
        .i_Clock          (i_Clock),
        .i_Reset          (i_Reset),
        .uart_config_data (uart_config_data),
        .i_Rx_Serial      (i_Rx_Serial),
        .o_Rx_DV          (o_Rx_DV),
        .o_Rx_Byte        (o_Rx_Byte),
        .o_Rx_Frame_Err   (o_Rx_Frame_Err),
        .o_Rx_Parity_Err  (o_Rx_Parity_Err),
        .o_Rx_Active      (o_Rx_Active)
    );

    always #5 i_Clock = ~i_Clock;

    always @(negedge i_Clock) begin
        if (o_Rx_DV === 1'b1) begin
            dv_count++;
            last_byte = o_Rx_Byte;
            last_ferr = o_Rx_Frame_Err;
            last_perr = o_Rx_Parity_Err;
            got_q.push_back(o_Rx_Byte);
            if (o_Rx_Frame_Err || o_Rx_Parity_Err) bad_flags++;
        end else if (o_Rx_Frame_Err === 1'b1 || o_Rx_Parity_Err === 1'b1) begin
            err_leak++;
        end
    end

    // All drivers start and end on a falling clock edge.
    task automatic send_bit(input logic b, input int cpb);
        i_Rx_Serial = b;
        repeat (cpb) @(negedge i_Clock);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop_b, input logic par_b, input int cpb);
        send_bit(1'b0, cpb);
        for (int i = 0; i < W; i++) send_bit(d[i], cpb);
`ifdef UART_RX_PARITY_EN
        send_bit(par_b, cpb);
`else
        if (par_b === 1'bx) i_Rx_Serial = 1'b1;
`endif
        send_bit(stop_b, cpb);
    endtask

    task automatic idle(input int n);
        i_Rx_Serial = 1'b1;
        repeat (n) @(negedge i_Clock);
    endtask

    task automatic test_reset;
        repeat (4) @(negedge i_Clock);
        checks++; if (o_Rx_DV !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", o_Rx_DV); end
        checks++; if (o_Rx_Byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", o_Rx_Byte); end
        checks++; if (o_Rx_Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", o_Rx_Frame_Err); end
        checks++; if (o_Rx_Parity_Err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", o_Rx_Parity_Err); end
        checks++; if (o_Rx_Active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", o_Rx_Active); end
        i_Reset = 1'b0;
        idle(5);
    endtask

    task automatic test_basic;
        int dv0;
        uart_config_data = 32'd3;
        dv0 = dv_count;
        send_frame(8'hA5, 1'b1, 1'b0, 4);
        idle(20);
        checks++; if (dv_count !== dv0 + 1) begin errors++; $display("FAIL basic_dv_count got %0d exp %0d", dv_count - dv0, 1); end
        checks++; if (last_byte !== 8'hA5) begin errors++; $display("FAIL basic_byte got %h exp a5", last_byte); end
        checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b exp 0", last_ferr); end
        checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL basic_perr got %b exp 0", last_perr); end
        checks++; if (o_Rx_Byte !== 8'hA5) begin errors++; $display("FAIL basic_byte_hold got %h exp a5", o_Rx_Byte); end
        checks++; if (o_Rx_Active !== 1'b0) begin errors++; $display("FAIL basic_active got %b exp 0", o_Rx_Active); end
    endtask

    task automatic test_false_start;
        int   dv0;
        logic saw_active;
        uart_config_data = 32'd3;
        dv0 = dv_count;
        saw_active = 1'b0;
        i_Rx_Serial = 1'b0;
        @(negedge i_Clock);
        i_Rx_Serial = 1'b1;
        repeat (8) begin
            @(negedge i_Clock);
            if (o_Rx_Active === 1'b1) saw_active = 1'b1;
        end
        checks++; if (saw_active !== 1'b1) begin errors++; $display("FAIL false_start_accept got %b exp 1", saw_active); end
        checks++; if (o_Rx_Active !== 1'b0) begin errors++; $display("FAIL false_start_active got %b exp 0", o_Rx_Active); end
        idle(20);
        checks++; if (dv_count !== dv0) begin errors++; $display("FAIL false_start_dv got %0d exp 0", dv_count - dv0); end
    endtask

    task automatic test_frame_err;
        int dv0;
        uart_config_data = 32'd3;
        dv0 = dv_count;
        send_frame(8'h3C, 1'b0, 1'b0, 4);
        repeat (20) @(negedge i_Clock);
        checks++; if (dv_count !== dv0 + 1) begin errors++; $display("FAIL ferr_dv_count got %0d exp 1", dv_count - dv0); end
        checks++; if (last_byte !== 8'h3C) begin errors++; $display("FAIL ferr_byte got %h exp 3c", last_byte); end
        checks++; if (last_ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", last_ferr); end
        checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL ferr_perr got %b exp 0", last_perr); end
        repeat (60) @(negedge i_Clock);
        checks++; if (dv_count !== dv0 + 1) begin errors++; $display("FAIL break_dv got %0d exp 1", dv_count - dv0); end
        checks++; if (o_Rx_Active !== 1'b0) begin errors++; $display("FAIL break_active got %b exp 0", o_Rx_Active); end
        idle(20);
        checks++; if (dv_count !== dv0 + 1) begin errors++; $display("FAIL break_release_dv got %0d exp 1", dv_count - dv0); end
    endtask

    task automatic test_cpb1;
        int dv0;
        idle(10);
        uart_config_data = 32'd0;
        dv0 = dv_count;
        send_frame(8'h96, 1'b1, 1'b0, 1);
        idle(20);
        checks++; if (dv_count !== dv0 + 1) begin errors++; $display("FAIL cpb1_dv_count got %0d exp 1", dv_count - dv0); end
        checks++; if (last_byte !== 8'h96) begin errors++; $display("FAIL cpb1_byte got %h exp 96", last_byte); end
        checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL cpb1_ferr got %b exp 0", last_ferr); end
    endtask

    task automatic test_cfg_change;
        int dv0;
        uart_config_data = 32'd3;
        idle(5);
        dv0 = dv_count;
        fork
            send_frame(8'h5A, 1'b1, 1'b0, 4);
            begin
                repeat (12) @(negedge i_Clock);
                uart_config_data = 32'd50;
            end
        join
        idle(20);
        checks++; if (dv_count !== dv0 + 1) begin errors++; $display("FAIL cfg_change_dv got %0d exp 1", dv_count - dv0); end
        checks++; if (last_byte !== 8'h5A) begin errors++; $display("FAIL cfg_change_byte got %h exp 5a", last_byte); end
        uart_config_data = 32'd3;
    endtask

    task automatic test_reset_mid_frame;
        int           dv0;
        logic [W-1:0] pat;
        uart_config_data = 32'd3;
        dv0 = dv_count;
        pat = 8'hF0;
        send_bit(1'b0, 4);
        for (int i = 0; i < 4; i++) send_bit(pat[i], 4);
        i_Rx_Serial = pat[4];
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b1;
        #1;
        checks++; if (o_Rx_DV !== 1'b0) begin errors++; $display("FAIL midrst_dv got %b exp 0", o_Rx_DV); end
        checks++; if (o_Rx_Byte !== 8'h00) begin errors++; $display("FAIL midrst_byte got %h exp 00", o_Rx_Byte); end
        checks++; if (o_Rx_Frame_Err !== 1'b0) begin errors++; $display("FAIL midrst_ferr got %b exp 0", o_Rx_Frame_Err); end
        checks++; if (o_Rx_Parity_Err !== 1'b0) begin errors++; $display("FAIL midrst_perr got %b exp 0", o_Rx_Parity_Err); end
        checks++; if (o_Rx_Active !== 1'b0) begin errors++; $display("FAIL midrst_active got %b exp 0", o_Rx_Active); end
        @(negedge i_Clock);
        i_Reset = 1'b0;
        idle(20);
        checks++; if (dv_count !== dv0) begin errors++; $display("FAIL midrst_abort_dv got %0d exp 0", dv_count - dv0); end
        send_frame(8'h81, 1'b1, 1'b0, 4);
        idle(20);
        checks++; if (dv_count !== dv0 + 1) begin errors++; $display("FAIL midrst_next_dv got %0d exp 1", dv_count - dv0); end
        checks++; if (last_byte !== 8'h81) begin errors++; $display("FAIL midrst_next_byte got %h exp 81", last_byte); end
        checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL midrst_next_ferr got %b exp 0", last_ferr); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int dv0;
        uart_config_data = 32'd3;
        dv0 = dv_count;
        send_frame(8'h07, 1'b1, 1'b0, 4);
        idle(20);
        checks++; if (dv_count !== dv0 + 1) begin errors++; $display("FAIL parity_bad_dv got %0d exp 1", dv_count - dv0); end
        checks++; if (last_perr !== 1'b1) begin errors++; $display("FAIL parity_bad_flag got %b exp 1", last_perr); end
        checks++; if (last_byte !== 8'h07) begin errors++; $display("FAIL parity_bad_byte got %h exp 07", last_byte); end
        send_frame(8'h07, 1'b1, 1'b1, 4);
        idle(20);
        checks++; if (dv_count !== dv0 + 2) begin errors++; $display("FAIL parity_good_dv got %0d exp 2", dv_count - dv0); end
        checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL parity_good_flag got %b exp 0", last_perr); end
    endtask
`endif

    task automatic test_back_to_back;
        int bad0;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        uart_config_data = 32'd437;
        idle(10);
        got_q.delete();
        exp_q = '{8'h00, 8'hFF, 8'h55};
        bad0 = bad_flags;
        send_frame(8'h00, 1'b1, 1'b0, 438);
        send_frame(8'hFF, 1'b1, 1'b0, 438);
        send_frame(8'h55, 1'b1, 1'b0, 438);
        idle(600);
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", got_q.size()); end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++; if (got !== exp) begin errors++; $display("FAIL b2b_byte got %h exp %h", got, exp); end
        end
        checks++; if (bad_flags !== bad0) begin errors++; $display("FAIL b2b_err_flags got %0d exp 0", bad_flags - bad0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_cpb1();
        test_cfg_change();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        checks++; if (err_leak !== 0) begin errors++; $display("FAIL err_without_dv got %0d exp 0", err_leak); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter UART_DATA_WIDTH, default 8, data bits per frame.
REQ-002 Parameter CONFIG_DATA_WIDTH, default 32, width of bit-period configuration word.
REQ-003 i_Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_Reset  input  1  asynchronous, active-high reset.
REQ-005 uart_config_data  input  CONFIG_DATA_WIDTH  clocks-per-bit minus 1 (CPB-1); same encoding as the transmitter.
REQ-006 i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-007 o_Rx_DV  output  1  one-cycle pulse: received frame complete.
REQ-008 o_Rx_Byte  output  UART_DATA_WIDTH  last received data, LSB first on the line; holds between frames.
REQ-009 o_Rx_Frame_Err  output  1  valid with o_Rx_DV; stop bit sampled low.
REQ-010 o_Rx_Parity_Err  output  1  valid with o_Rx_DV; parity mismatch (see Configuration).
REQ-011 o_Rx_Active  output  1  high from start-bit acceptance until CLEANUP.

Function
REQ-012 i_Rx_Serial SHALL pass a 2-flop synchronizer; all logic uses the synchronized value and its 1-cycle-delayed copy.
REQ-013 States: IDLE, START, DATA, PARITY (macro only), STOP, CLEANUP; unused encodings SHALL return to IDLE.
REQ-014 IDLE: counter and bit index cleared; on synchronized falling edge (prev 1, now 0) SHALL latch uart_config_data into r_config_data and enter START.
REQ-015 uart_config_data changes mid-frame SHALL NOT affect the frame in progress.
REQ-016 START: count to r_config_data>>1 (mid-bit); line low -> clear counter, enter DATA; line high -> false start, return to IDLE with no o_Rx_DV.
REQ-017 DATA: every r_config_data+1 clocks after mid-start, SHALL sample the line into bit r_Bit_Index; after bit UART_DATA_WIDTH-1, go to PARITY (macro) or STOP.
REQ-018 STOP: sample after r_config_data+1 clocks; SHALL update o_Rx_Byte, set o_Rx_Frame_Err = ~sample, pulse o_Rx_DV for exactly one cycle, enter CLEANUP.
REQ-019 A frame with framing error SHALL still deliver its data byte.
REQ-020 CLEANUP: one cycle, deassert o_Rx_Active, return to IDLE; a line held low (break) SHALL NOT start a new frame until a high-to-low edge occurs.
REQ-021 Counter compares use full CONFIG_DATA_WIDTH; r_config_data = 0 (CPB 1) SHALL function with half-count 0.
REQ-022 o_Rx_Frame_Err/o_Rx_Parity_Err SHALL be 0 whenever o_Rx_DV is 0.

Reset
REQ-023 On i_Reset: state IDLE, counters 0, synchronizer flops 1, o_Rx_DV 0, o_Rx_Byte 0, both error outputs 0, o_Rx_Active 0, r_config_data 437.
REQ-024 Reset mid-frame SHALL abort silently with no o_Rx_DV pulse.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: one even-parity bit follows data bits, sampled in PARITY one bit-period after last data bit; o_Rx_Parity_Err = XOR(data, parity bit).
REQ-026 Macro undefined: no PARITY state, frame is start+data+stop, o_Rx_Parity_Err tied 0.

Structure
REQ-027 Package uart_pkg SHALL hold state encodings, reset bit-period constant (437) and default widths, shared with uart_tx.
REQ-028 One sub-module, uart_sync2 (2-flop synchronizer, reset value 1); remainder flat.

Verification
REQ-029 config 3, send 0xA5 with valid stop -> single o_Rx_DV pulse, o_Rx_Byte 0xA5, both errors 0.
REQ-030 config 3, line low 1 clock then high -> false start, no o_Rx_DV, o_Rx_Active back to 0 by mid-bit+2 cycles.
REQ-031 config 3, 0x3C with stop bit low -> o_Rx_DV with o_Rx_Byte 0x3C, o_Rx_Frame_Err 1; line held low afterwards -> no further o_Rx_DV.
REQ-032 Loopback from uart_tx at default 437, bytes 0x00, 0xFF, 0x55 back-to-back -> three pulses in order, no errors.
REQ-033 UART_RX_PARITY_EN, config 3, 0x07 with parity bit 0 -> o_Rx_Parity_Err 1; with parity bit 1 -> 0.
REQ-034 i_Reset asserted during bit 4 of a frame -> outputs at reset values immediately, next clean frame 0x81 received correctly.
